// File: rtl/axi_lite_resp_mem.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_resp_mem
// Brief    : AXI4-Lite slave backed by a word-addressed register memory,
//            with OKAY/SLVERR responses and a saturating error counter.
// Revision : 1.0
// ============================================================================
module axi_lite_resp_mem #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter int MEM_DEPTH          = 16
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [7:0]                      ERR_COUNT
);

    localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
    localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [IDX_W:0] DEPTH_LIM = (IDX_W + 1)'(MEM_DEPTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] W_IDLE     = 2'd0;
    localparam logic [1:0] W_GOT_ADDR = 2'd1;
    localparam logic [1:0] W_GOT_DATA = 2'd2;
    localparam logic [1:0] W_RESP     = 2'd3;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    logic [C_S_AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                          live;
    logic [1:0]                    w_state;
    logic [0:0]                    r_state;
    logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]             w_strb_q;
    logic [1:0]                    bresp;
    logic [1:0]                    rresp;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata;
    logic [7:0]                    err_count;

    logic                          aw_hs;
    logic                          w_hs;
    logic                          ar_hs;
    logic                          w_commit;
    logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]             wr_strb;
    logic [IDX_W-1:0]              wr_idx;
    logic [IDX_W-1:0]              rd_idx;
    logic                          wr_in_range;
    logic                          rd_in_range;
    logic [1:0]                    err_inc;
    logic [8:0]                    err_sum;
    logic                          unused_ok;

    // Readies stay low until the first edge after reset release.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    assign S_AXI_AWREADY = live && ((w_state == W_IDLE) || (w_state == W_GOT_DATA));
    assign S_AXI_WREADY  = live && ((w_state == W_IDLE) || (w_state == W_GOT_ADDR));
    assign S_AXI_BVALID  = (w_state == W_RESP);
    assign S_AXI_BRESP   = bresp;
    assign S_AXI_ARREADY = live && (r_state == R_IDLE);
    assign S_AXI_RVALID  = (r_state == R_DATA);
    assign S_AXI_RRESP   = rresp;
    assign S_AXI_RDATA   = rdata;
    assign ERR_COUNT     = err_count;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // Whichever half arrived first comes from the latch, the other is live.
    assign wr_addr = (w_state == W_GOT_ADDR) ? aw_addr_q : S_AXI_AWADDR;
    assign wr_data = (w_state == W_GOT_DATA) ? w_data_q : S_AXI_WDATA;
    assign wr_strb = (w_state == W_GOT_DATA) ? w_strb_q : S_AXI_WSTRB;

    assign w_commit = ((w_state == W_IDLE) && aw_hs && w_hs) ||
                      ((w_state == W_GOT_ADDR) && w_hs) ||
                      ((w_state == W_GOT_DATA) && aw_hs);

    assign wr_idx      = wr_addr[C_S_AXI_ADDR_WIDTH-1:2];
    assign rd_idx      = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_in_range = ({1'b0, wr_idx} < DEPTH_LIM);
    assign rd_in_range = ({1'b0, rd_idx} < DEPTH_LIM);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state   <= W_IDLE;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp     <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs && w_hs) begin
                        w_state <= W_RESP;
                    end else if (aw_hs) begin
                        aw_addr_q <= S_AXI_AWADDR;
                        w_state   <= W_GOT_ADDR;
                    end else if (w_hs) begin
                        w_data_q <= S_AXI_WDATA;
                        w_strb_q <= S_AXI_WSTRB;
                        w_state  <= W_GOT_DATA;
                    end
                end
                W_GOT_ADDR: begin
                    if (w_hs) begin
                        w_state <= W_RESP;
                    end
                end
                W_GOT_DATA: begin
                    if (aw_hs) begin
                        w_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
            if (w_commit) begin
                bresp <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (w_commit && wr_in_range) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx[MEM_AW-1:0]][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // The read samples mem before any same-edge write lands.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state <= R_IDLE;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_state <= R_DATA;
                        rdata   <= rd_in_range ? mem[rd_idx[MEM_AW-1:0]] : '0;
                        rresp   <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign err_inc = {1'b0, (w_commit && !wr_in_range)} + {1'b0, (ar_hs && !rd_in_range)};
    assign err_sum = {1'b0, err_count} + {7'b0, err_inc};

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            err_count <= 8'd0;
        end else if (err_sum[8]) begin
            err_count <= 8'hFF;
        end else begin
            err_count <= err_sum[7:0];
        end
    end

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr[1:0], S_AXI_ARADDR[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_resp_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_resp_mem
// Brief    : Directed scoreboard bench for axi_lite_resp_mem.
// Revision : 1.0
// ============================================================================
module tb_axi_lite_resp_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [7:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;
    int err_model = 0;
    logic [31:0] model [16];
    logic [1:0]  bexp [$];
    logic [33:0] rexp [$];

    axi_lite_resp_mem #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(8),
        .MEM_DEPTH(16)
    ) dut (
        .ACLK(clk),
        .ARESET(rst),
        .S_AXI_AWADDR(awaddr),
        .S_AXI_AWPROT(awprot),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata),
        .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp),
        .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr),
        .S_AXI_ARPROT(arprot),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata),
        .S_AXI_RRESP(rresp),
        .S_AXI_RVALID(rvalid),
        .S_AXI_RREADY(rready),
        .ERR_COUNT(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic in_rng(input logic [7:0] a);
        return (a[7:6] == 2'b00);
    endfunction

    function automatic logic [31:0] exp_err();
        return (err_model > 255) ? 32'd255 : 32'(err_model);
    endfunction

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int w_delay, input int b_delay, input bit take_resp);
        int n;
        if (in_rng(a)) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) model[a[5:2]][8*b +: 8] = d[8*b +: 8];
            end
            bexp.push_back(2'b00);
        end else begin
            bexp.push_back(2'b10);
            err_model++;
        end
        @(negedge clk);
        awaddr = a; awvalid = 1'b1;
        wdata = d; wstrb = s; wvalid = (w_delay == 0);
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        check("awready_wait", 32'(awready), 32'd1);
        if (w_delay > 0) begin
            for (int i = 0; i < w_delay; i++) begin
                @(negedge clk);
                awvalid = 1'b0;
                check("awready_low_waiting_w", 32'(awready), 32'd0);
                check("bvalid_before_w", 32'(bvalid), 32'd0);
            end
            wvalid = 1'b1;
            n = 0;
            while (!wready && n < 20) begin @(negedge clk); n++; end
            check("wready_wait", 32'(wready), 32'd1);
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("bvalid_latency", 32'(bvalid), 32'd1);
        if (!take_resp) return;
        for (int i = 0; i < b_delay; i++) begin
            check("bvalid_hold", 32'(bvalid), 32'd1);
            check("bresp_hold", 32'(bresp), 32'(bexp[0]));
            check("awready_during_b", 32'(awready), 32'd0);
            @(negedge clk);
        end
        bready = 1'b1;
        check("bresp", 32'(bresp), 32'(bexp.pop_front()));
        @(negedge clk);
        bready = 1'b0;
        check("bvalid_clear", 32'(bvalid), 32'd0);
        check("awready_after_b", 32'(awready), 32'd1);
        check("err_count_w", 32'(err_count), exp_err());
    endtask

    task automatic do_read(input logic [7:0] a, input int r_delay);
        int n;
        logic [33:0] e;
        if (in_rng(a)) begin
            rexp.push_back({2'b00, model[a[5:2]]});
        end else begin
            rexp.push_back({2'b10, 32'h0});
            err_model++;
        end
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        check("arready_wait", 32'(arready), 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        check("rvalid_latency", 32'(rvalid), 32'd1);
        for (int i = 0; i < r_delay; i++) begin
            e = rexp[0];
            check("rvalid_hold", 32'(rvalid), 32'd1);
            check("rdata_hold", rdata, e[31:0]);
            check("rresp_hold", 32'(rresp), 32'(e[33:32]));
            check("arready_during_r", 32'(arready), 32'd0);
            @(negedge clk);
        end
        rready = 1'b1;
        e = rexp.pop_front();
        check("rdata", rdata, e[31:0]);
        check("rresp", 32'(rresp), 32'(e[33:32]));
        @(negedge clk);
        rready = 1'b0;
        check("rvalid_clear", 32'(rvalid), 32'd0);
        check("err_count_r", 32'(err_count), exp_err());
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 16; i++) model[i] = 32'h0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_bresp", 32'(bresp), 32'd0);
        check("rst_rresp", 32'(rresp), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        rst = 1'b0;
        check("ready_before_edge", 32'(awready), 32'd0);
        @(negedge clk);
        check("awready_after_edge", 32'(awready), 32'd1);
        check("wready_after_edge", 32'(wready), 32'd1);
        check("arready_after_edge", 32'(arready), 32'd1);

        // Basic write and read back
        do_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 0, 1'b1);
        do_read(8'h04, 0);

        // AW first, W delayed, partial strobes over preloaded word
        do_write(8'h0C, 32'hAABBCCDD, 4'hF, 0, 0, 1'b1);
        do_write(8'h0C, 32'h11223344, 4'b0101, 3, 0, 1'b1);
        do_read(8'h0C, 0);
        check("strobe_merge_model", model[3], 32'hAA22CC44);

        // Out of range write/read
        do_write(8'h40, 32'hCAFEF00D, 4'hF, 0, 0, 1'b1);
        do_read(8'h40, 0);
        check("err_count_two", 32'(err_count), 32'd2);
        do_read(8'h00, 0);

        // Backpressure on both response channels
        do_write(8'h10, 32'h12345678, 4'hF, 0, 5, 1'b1);
        do_read(8'h10, 5);
        do_write(8'h3C, 32'h0BADF00D, 4'hF, 0, 5, 1'b1);
        do_read(8'h3C, 5);

        // Saturation
        for (int i = 0; i < 300; i++) do_read(8'hFC, 0);
        check("err_count_saturated", 32'(err_count), 32'd255);

        // Reset while a write response is pending
        do_write(8'h08, 32'h5A5A5A5A, 4'hF, 0, 0, 1'b0);
        check("bvalid_pending", 32'(bvalid), 32'd1);
        rst = 1'b1;
        #1;
        check("bvalid_async_drop", 32'(bvalid), 32'd0);
        check("awready_async_drop", 32'(awready), 32'd0);
        check("err_count_async_clear", 32'(err_count), 32'd0);
        void'(bexp.pop_front());
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        err_model = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("awready_after_rst2", 32'(awready), 32'd1);
        do_read(8'h08, 0);
        do_read(8'h04, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
